// File: rtl/ring_shift_controller.sv
// Ring shift controller: loads a 6-bit pattern on start and rotates it a
// programmed number of single-bit steps, with pause, busy and a done pulse.
// Optional feature macro: RING_ROTATE_RIGHT_EN adds a 'dir' input, captured
// on the start-accept edge, that selects right rotation when high.
module ring_shift_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] load_val,
    input  logic [2:0] steps,
    input  logic       pause,
`ifdef RING_ROTATE_RIGHT_EN
    input  logic       dir,
`endif
    output logic [5:0] q,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] ring_q, ring_d;
    logic [2:0] cnt_q, cnt_d;
    logic [5:0] ring_rot;

`ifdef RING_ROTATE_RIGHT_EN
    logic dir_q, dir_d;

    // Direction is latched at start so later changes cannot disturb a rotation.
    always_comb begin
        ring_rot = dir_q ? {ring_q[0], ring_q[5:1]} : {ring_q[4:0], ring_q[5]};
    end
`else
    // Left rotation only: bit 5 wraps around into bit 0.
    always_comb begin
        ring_rot = {ring_q[4:0], ring_q[5]};
    end
`endif

    // Next-state logic: capture on start in idle, rotate while shifting unpaused.
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        cnt_d   = cnt_q;
`ifdef RING_ROTATE_RIGHT_EN
        dir_d   = dir_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ring_d  = load_val;
                    cnt_d   = steps;
`ifdef RING_ROTATE_RIGHT_EN
                    dir_d   = dir;
`endif
                    state_d = (steps != 3'd0) ? StShift : StDone;
                end
            end
            StShift: begin
                if (!pause) begin
                    ring_d = ring_rot;
                    cnt_d  = cnt_q - 3'd1;
                    // Last rotation happens on this edge.
                    if (cnt_q == 3'd1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ring_q  <= 6'b000000;
            cnt_q   <= 3'd0;
`ifdef RING_ROTATE_RIGHT_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            cnt_q   <= cnt_d;
`ifdef RING_ROTATE_RIGHT_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // Outputs decoded straight from registered state.
    always_comb begin
        q    = ring_q;
        busy = (state_q == StShift);
        done = (state_q == StDone);
    end

endmodule

// File: tb/tb_ring_shift_controller.sv
// Self-checking bench for ring_shift_controller: directed literal checks plus
// randomized traffic compared every cycle against an operation-level model.
module tb_ring_shift_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] load_val;
    logic [2:0] steps;
    logic       pause;
    logic       dir;
    logic [5:0] q;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    ring_shift_controller dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .load_val (load_val),
        .steps    (steps),
        .pause    (pause),
`ifdef RING_ROTATE_RIGHT_EN
        .dir      (dir),
`endif
        .q        (q),
        .busy     (busy),
        .done     (done)
    );

    // Model: an operation is a base pattern, a target rotation count n and the
    // number of rotations k applied so far; q is base rotated by k.
    int m_base, m_n, m_k;
    bit m_active, m_done, m_dir;

    function automatic int rot(input int b, input int k, input bit right);
        int kk;
        kk = k % 6;
        if (right) return ((b >> kk) | (b << (6 - kk))) & 63;
        else       return ((b << kk) | (b >> (6 - kk))) & 63;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_base <= 0; m_n <= 0; m_k <= 0;
            m_active <= 1'b0; m_done <= 1'b0; m_dir <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_active) begin
            if (!pause) begin
                m_k <= m_k + 1;
                if (m_k + 1 == m_n) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
            end
        end else if (start) begin
            m_base <= int'(load_val);
            m_n    <= int'(steps);
            m_k    <= 0;
`ifdef RING_ROTATE_RIGHT_EN
            m_dir  <= dir;
`else
            m_dir  <= 1'b0;
`endif
            if (steps == 3'd0) m_done <= 1'b1;
            else               m_active <= 1'b1;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q", int'(q), rot(m_base, m_k, m_dir));
            check("model_busy", int'(busy), int'(m_active));
            check("model_done", int'(done), int'(m_done));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int eq, input int eb, input int ed);
        check({name, "_q"}, int'(q), eq);
        check({name, "_busy"}, int'(busy), eb);
        check({name, "_done"}, int'(done), ed);
    endtask

    // Tick until done is seen; cyc = ticks taken, -1 if the bound expires.
    task automatic run_to_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    int cyc;
    int exp_q [5] = '{1, 2, 4, 8, 8};
    int exp_b [5] = '{1, 1, 1, 0, 0};
    int exp_d [5] = '{0, 0, 0, 1, 0};

    initial begin
        reset = 1'b1; start = 1'b0; load_val = 6'd0; steps = 3'd0;
        pause = 1'b0; dir = 1'b0;
        tick();
        chk_en = 1'b1;
        lit("reset1", 0, 0, 0);
        tick();
        lit("reset2", 0, 0, 0);
        reset = 1'b0;
        tick();
        lit("release", 0, 0, 0);

        // Rotate 000001 three steps.
        start = 1'b1; load_val = 6'b000001; steps = 3'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            lit($sformatf("steps3_%0d", i), exp_q[i], exp_b[i], exp_d[i]);
        end

        // Zero steps goes straight to done.
        start = 1'b1; load_val = 6'b101010; steps = 3'd0;
        tick();
        start = 1'b0;
        lit("steps0_a", 42, 0, 1);
        tick();
        lit("steps0_b", 42, 0, 0);

        // Full wrap; inputs changed after capture must not matter.
        start = 1'b1; load_val = 6'b100011; steps = 3'd6;
        tick();
        start = 1'b0; load_val = 6'd0; steps = 3'd1;
        run_to_done(cyc);
        check("steps6_latency", cyc, 6);
        check("steps6_q", int'(q), 35);
        tick();

        start = 1'b1; load_val = 6'b100011; steps = 3'd7;
        tick();
        start = 1'b0;
        run_to_done(cyc);
        check("steps7_latency", cyc, 7);
        check("steps7_q", int'(q), 7);
        tick();

        // Pause for two cycles after the first rotation; mid-op start ignored.
        start = 1'b1; load_val = 6'b000001; steps = 3'd4;
        tick();
        start = 1'b0;
        lit("pause_e0", 1, 1, 0);
        tick();
        lit("pause_e1", 2, 1, 0);
        pause = 1'b1;
        tick();
        lit("pause_e2", 2, 1, 0);
        tick();
        lit("pause_e3", 2, 1, 0);
        pause = 1'b0; start = 1'b1; load_val = 6'b111111; steps = 3'd1;
        tick();
        lit("pause_e4", 4, 1, 0);
        start = 1'b0;
        tick();
        lit("pause_e5", 8, 1, 0);
        tick();
        lit("pause_e6", 16, 0, 1);
        tick();
        lit("pause_e7", 16, 0, 0);

        // Reset mid-shift aborts with no done pulse.
        start = 1'b1; load_val = 6'b000001; steps = 3'd5;
        tick();
        start = 1'b0;
        tick();
        lit("abort_pre", 2, 1, 0);
        reset = 1'b1;
        tick();
        lit("abort_rst", 0, 0, 0);
        reset = 1'b0;
        tick();
        lit("abort_post", 0, 0, 0);

`ifdef RING_ROTATE_RIGHT_EN
        // Right rotation; dir change after capture is ignored.
        dir = 1'b1; start = 1'b1; load_val = 6'b000001; steps = 3'd2;
        tick();
        dir = 1'b0; start = 1'b0;
        lit("right_e0", 1, 1, 0);
        tick();
        lit("right_e1", 32, 1, 0);
        tick();
        lit("right_e2", 16, 0, 1);
        tick();
`endif

        // Randomized traffic checked by the per-cycle model comparison.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            start    = ($urandom_range(0, 2) == 0);
            pause    = ($urandom_range(0, 3) == 0);
            load_val = 6'($urandom);
            steps    = 3'($urandom);
`ifdef RING_ROTATE_RIGHT_EN
            dir      = 1'($urandom);
`endif
            tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_shift_controller.md
RING_SHIFT_CONTROLLER -- requirements
Module: ring_shift_controller

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to load a pattern and rotate it; sampled only in IDLE.
REQ-005 Port: load_val  input  6  pattern written into the ring on the start-accept edge.
REQ-006 Port: steps  input  3  number of single-bit rotations (0..7); captured on the start-accept edge.
REQ-007 Port: pause  input  1  while high in SHIFT, rotation and step counter freeze.
REQ-008 Port: q  output  6  current ring contents, registered.
REQ-009 Port: busy  output  1  high in SHIFT state only.
REQ-010 Port: done  output  1  single-cycle pulse, high in DONE state only.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; busy and done are decoded from registered state.
REQ-012 IDLE with start=1 at an edge: q<=load_val, cnt<=steps; next state SHIFT if steps!=0, else DONE.
REQ-013 IDLE with start=0: q, cnt hold; state stays IDLE.
REQ-014 SHIFT with pause=0: q<={q[4:0],q[5]} (rotate left, bit 5 wraps to bit 0), cnt<=cnt-1; when cnt==1 next state DONE, else stay SHIFT.
REQ-015 SHIFT with pause=1: q, cnt, state all hold; busy stays 1.
REQ-016 DONE: q holds; next state IDLE unconditionally; start in DONE is ignored.
REQ-017 start asserted in SHIFT or DONE SHALL be ignored (no restart, no capture).
REQ-018 Latency: start-accept edge E0, rotations at edges E1..En (n=steps, no pause), done high for the cycle following En; steps=0 gives done in the cycle following E0.
REQ-019 cnt is 3 bits, never underflows; steps=7 performs exactly 7 rotations.
REQ-020 steps=6 SHALL return q to load_val (full ring wrap).
REQ-021 load_val and steps changes after E0 SHALL not affect the operation in progress.

Reset
REQ-022 reset=1 at an edge SHALL force state=IDLE, q=6'b000000, cnt=0, busy=0, done=0, with priority over start, pause and any state.
REQ-023 reset mid-SHIFT SHALL abort the operation with no done pulse.

Configuration
REQ-024 Macro RING_ROTATE_RIGHT_EN: when defined, adds port dir  input  1, captured on the start-accept edge; dir=1 rotates right q<={q[0],q[5:1]}, dir=0 rotates left; the captured direction is cleared to 0 by reset.
REQ-025 Without RING_ROTATE_RIGHT_EN: no dir port; rotation is left only per REQ-014.

Verification
REQ-026 Assert reset 2 cycles -> q=000000, busy=0, done=0; release with start=0 -> outputs unchanged.
REQ-027 start=1, load_val=000001, steps=3 -> q sequence 000001, 000010, 000100, 001000; done high one cycle with q=001000; busy high exactly 3 cycles.
REQ-028 start=1, load_val=101010, steps=0 -> q=101010, busy never high, done pulses the next cycle.
REQ-029 load_val=100011, steps=6 -> q ends at 100011; steps=7 -> q ends at 000111.
REQ-030 load_val=000001, steps=4, pause high 2 cycles after the first rotation -> q holds 000010 for 2 cycles; done arrives 2 cycles later than unpaused; start pulsed mid-operation -> ignored.
REQ-031 reset asserted during SHIFT -> next cycle q=000000, busy=0, no done pulse; with RING_ROTATE_RIGHT_EN, dir=1, load_val=000001, steps=2 -> q 000001, 100000, 010000.
